// File: rtl/nes_controller_reader.sv
// rtl/nes_controller_reader.sv - NES gamepad poller: serial latch/pulse/data to parallel button byte
//
// Purpose: every POLL_STEPS idle steps, strobe latch for 2 steps, then clock
// out 8 bits from the pad (sample on pulse-low steps, 7 one-step pulse highs)
// and publish them as an active-high byte with a one-cycle valid strobe.
// A "step" is one rising edge of stepClock, detected in the inClock domain.
//
// Ports:
//   inClock    system clock, all logic on posedge
//   reset      synchronous active-low reset
//   stepClock  divided timing clock (6 us period), rising edges only
//   dataIn     raw pad data pin, active-low
//   latch      pad latch strobe (registered)
//   pulse      pad clock pulse (registered)
//   buttons    {Right, Left, Down, Up, Start, Select, B, A}, 1 = pressed
//   valid      one inClock cycle when buttons updates

module nes_controller_reader #(
    parameter int POLL_STEPS = 2778
) (
    input  logic       inClock,
    input  logic       reset,
    input  logic       stepClock,
    input  logic       dataIn,
    output logic       latch,
    output logic       pulse,
    output logic [7:0] buttons,
    output logic       valid
);

    typedef enum logic [1:0] {
        WAIT     = 2'd0,
        LATCH    = 2'd1,
        SHIFT_LO = 2'd2,
        SHIFT_HI = 2'd3
    } state_t;

    localparam logic [15:0] POLL_LAST = 16'(POLL_STEPS - 1);

    state_t      state, state_n;
    logic [15:0] count, count_n;
    logic [2:0]  bitIdx, bitIdx_n;
    logic [7:0]  shift, shift_n;
    logic        latch_n, pulse_n, valid_n;
    logic [7:0]  buttons_n;

    logic stepPrev;
    logic step;
    logic dataMeta;
    logic dataSync;

    assign step = stepClock & ~stepPrev;

    // Edge detector and pad-data synchronizer. stepPrev follows stepClock even
    // in reset so a high stepClock at release is not mistaken for an edge.
    always_ff @(posedge inClock) begin
        stepPrev <= stepClock;
        if (!reset) begin
            dataMeta <= 1'b1;
            dataSync <= 1'b1;
        end else begin
            dataMeta <= dataIn;
            dataSync <= dataMeta;
        end
    end

    always_ff @(posedge inClock) begin
        if (!reset) begin
            state   <= WAIT;
            count   <= 16'd0;
            bitIdx  <= 3'd0;
            shift   <= 8'h00;
            latch   <= 1'b0;
            pulse   <= 1'b0;
            buttons <= 8'h00;
            valid   <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            bitIdx  <= bitIdx_n;
            shift   <= shift_n;
            latch   <= latch_n;
            pulse   <= pulse_n;
            buttons <= buttons_n;
            valid   <= valid_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        bitIdx_n  = bitIdx;
        shift_n   = shift;
        latch_n   = latch;
        pulse_n   = pulse;
        buttons_n = buttons;
        valid_n   = 1'b0;

        if (step) begin
            case (state)
                WAIT: begin
                    if (count == POLL_LAST) begin
                        count_n = 16'd0;
                        latch_n = 1'b1;
                        state_n = LATCH;
                    end else begin
                        count_n = count + 16'd1;
                    end
                end
                LATCH: begin
                    if (count == 16'd1) begin
                        count_n  = 16'd0;
                        latch_n  = 1'b0;
                        bitIdx_n = 3'd0;
                        state_n  = SHIFT_LO;
                    end else begin
                        count_n = count + 16'd1;
                    end
                end
                SHIFT_LO: begin
                    shift_n[bitIdx] = ~dataSync;
                    if (bitIdx == 3'd7) begin
                        // The last bit is not in shift yet; forward it directly.
                        buttons_n = {~dataSync, shift[6:0]};
                        valid_n   = 1'b1;
                        state_n   = WAIT;
                    end else begin
                        pulse_n = 1'b1;
                        state_n = SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    pulse_n  = 1'b0;
                    bitIdx_n = bitIdx + 3'd1;
                    state_n  = SHIFT_LO;
                end
                default: state_n = WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
// tb/tb_nes_controller_reader.sv - scoreboard bench for nes_controller_reader

module tb_nes_controller_reader;

    localparam int POLL = 4;

    logic       inClock = 1'b0;
    logic       reset = 1'b0;
    logic       stepClock = 1'b1;
    logic       dataIn = 1'b1;
    logic       latch, pulse, valid;
    logic [7:0] buttons;

    nes_controller_reader #(.POLL_STEPS(POLL)) dut (
        .inClock   (inClock),
        .reset     (reset),
        .stepClock (stepClock),
        .dataIn    (dataIn),
        .latch     (latch),
        .pulse     (pulse),
        .buttons   (buttons),
        .valid     (valid)
    );

    always #5 inClock = ~inClock;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pat = 8'h09;
    logic [7:0] exp_byte;
    bit   step_run = 1'b0;
    bit   glitch_en = 1'b0;
    bit   glitch = 1'b0;
    bit   first = 1'b1;
    bit   in_frame = 1'b0;
    int   ph = 0;
    int   step_cnt = 0;
    int   prev_latch_step = 0;
    int   latch_step = 0;
    int   pulse_cnt = 0;
    int   valid_cnt = 0;
    int   pad_idx = 0;
    logic latch_q = 1'b0, pulse_q = 1'b0, valid_q = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor, pad model and stepClock generator share one negedge process so
    // their relative ordering is fixed.
    always @(negedge inClock) begin
        if (!reset) begin
            exp_q.delete();
            in_frame = 1'b0;
            if (valid) check_eq("valid_in_reset", 32'(valid), 32'd0);
        end else begin
            if (latch && !latch_q) begin
                check_eq("latch_period", 32'(step_cnt - prev_latch_step),
                         first ? 32'(POLL) : 32'(POLL + 17));
                prev_latch_step = step_cnt;
                first = 1'b0;
                latch_step = step_cnt;
                pulse_cnt = 0;
                in_frame = 1'b1;
                exp_q.push_back(pat);
            end
            if (!latch && latch_q && in_frame)
                check_eq("latch_width", 32'(step_cnt - latch_step), 32'd2);
            if (pulse && !pulse_q) pulse_cnt++;
            if (latch && pulse) check_eq("latch_pulse_overlap", 32'd1, 32'd0);
            if (valid && valid_q) check_eq("valid_width", 32'd2, 32'd1);
            if (valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check_eq("buttons", 32'(buttons), 32'(exp_byte));
                    check_eq("pulse_count", 32'(pulse_cnt), 32'd7);
                    check_eq("frame_steps", 32'(step_cnt - latch_step), 32'd17);
                end
                in_frame = 1'b0;
            end
        end

        // Pad: latch reloads bit 0, each pulse rising edge advances one bit.
        if (latch) pad_idx = 0;
        else if (pulse && !pulse_q && pad_idx < 8) pad_idx++;
        latch_q = latch;
        pulse_q = pulse;
        valid_q = valid;

        if (step_run) begin
            ph++;
            if (ph == 5) begin
                ph = 0;
                stepClock = ~stepClock;
                if (stepClock) step_cnt++;
            end
        end
        // One-cycle glitch ending 3 cycles before each rising step edge.
        glitch = glitch_en && step_run && !stepClock && (ph == 1);
        dataIn = ((pad_idx < 8) ? ~pat[pad_idx[2:0]] : 1'b1) ^ glitch;
    end

    task automatic wait_valid(input string tag);
        int target;
        target = valid_cnt + 1;
        for (int i = 0; i < 600 && valid_cnt < target; i++) @(negedge inClock);
        check_eq({tag, "_done"}, 32'(valid_cnt >= target), 32'd1);
    endtask

    task automatic wait_pulse(input int n, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge inClock);
            hit = pulse && (pulse_cnt == n);
        end
        check_eq({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    task automatic release_reset();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge inClock);
            ok = !step_run || (!stepClock && ph <= 2);
        end
        reset = 1'b1;
        prev_latch_step = step_cnt;
        first = 1'b1;
    endtask

    initial begin
        int changes;
        logic l0, p0;
        logic [7:0] b0;

        reset = 1'b0;
        repeat (5) @(negedge inClock);
        check_eq("reset_latch", 32'(latch), 32'd0);
        check_eq("reset_pulse", 32'(pulse), 32'd0);
        check_eq("reset_buttons", 32'(buttons), 32'd0);
        check_eq("reset_valid", 32'(valid), 32'd0);
        release_reset();
        step_run = 1'b1;

        pat = 8'h09;
        wait_valid("frame_09");
        pat = 8'h00;
        wait_valid("frame_00");
        pat = 8'hFF;
        wait_valid("frame_ff");

        pat = 8'h5A;
        wait_pulse(4, "shift_hi_bit3");
        reset = 1'b0;
        @(negedge inClock);
        check_eq("midreset_latch", 32'(latch), 32'd0);
        check_eq("midreset_pulse", 32'(pulse), 32'd0);
        check_eq("midreset_buttons", 32'(buttons), 32'd0);
        repeat (2) @(negedge inClock);
        release_reset();
        wait_valid("after_reset");

        pat = 8'hC3;
        wait_pulse(2, "stall_point");
        step_run = 1'b0;
        l0 = latch;
        p0 = pulse;
        b0 = buttons;
        changes = 0;
        repeat (200) begin
            @(negedge inClock);
            if (latch !== l0 || pulse !== p0 || buttons !== b0 || valid) changes++;
        end
        check_eq("stall_frozen", 32'(changes), 32'd0);
        step_run = 1'b1;
        wait_valid("after_stall");

        pat = 8'h81;
        glitch_en = 1'b1;
        wait_valid("glitch");
        glitch_en = 1'b0;

        repeat (3) @(negedge inClock);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
Polls an NES gamepad over its 3-wire serial interface (latch, pulse, data) and presents the 8 button states as a parallel, active-high byte. Sits directly downstream of the clock divider. The divider's outClock drives stepClock, with speed set so one stepClock period = 6 us (≈166_667 Hz). Every timing step is one rising edge of stepClock, detected synchronously in the inClock domain. No second clock domain exists.

Parameters:
POLL_STEPS, 2778, steps spent idle between frames (2778 × 6 us ≈ 16.7 ms, i.e. 60 Hz polling); legal range 1..65535.

Ports:
inClock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
stepClock  input  1  divided clock from the clock divider; only its rising edges are used.
dataIn  input  1  controller serial data, raw pad pin, active-low (0 = pressed).
latch  output  1  controller latch strobe.
pulse  output  1  controller clock pulse.
buttons  output  8  bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right; 1 = pressed.
valid  output  1  one-inClock-cycle strobe when buttons updates.

Behaviour:
- Step detect:
  - stepPrev is registered from stepClock every cycle.
  - step = stepClock & ~stepPrev.
  - During reset, stepPrev <= stepClock, so a high stepClock at reset release gives no spurious step.
- Data input:
  - dataIn passes through a 2-flop synchronizer to give dataSync; both flops reset to 1.
  - All sampling uses dataSync.
- Reset values: state WAIT, count 0, bitIdx 0, shift 0, latch 0, pulse 0, buttons 8'h00, valid 0.
  - Reset mid-frame aborts the frame immediately; buttons are not updated.
- FSM: all transitions happen only on cycles where step==1; otherwise hold. Register widths: count 16 bits, bitIdx 3 bits.
  - WAIT:
    - If count==POLL_STEPS-1: count<=0, latch<=1, go to LATCH.
    - Else count<=count+1.
  - LATCH:
    - If count==1: count<=0, latch<=0, bitIdx<=0, go to SHIFT_LO.
    - Else count<=count+1.
    - Latch is high for exactly 2 steps (12 us).
  - SHIFT_LO (pulse low, pad data stable):
    - shift[bitIdx] <= ~dataSync.
    - If bitIdx==7: buttons <= {~dataSync, shift[6:0]}, valid<=1 for that cycle, go to WAIT. The new bit is forwarded combinationally into the update.
    - Else pulse<=1, go to SHIFT_HI.
  - SHIFT_HI:
    - pulse<=0, bitIdx<=bitIdx+1, go to SHIFT_LO.
- Frame timing:
  - Latch: 2 steps. Data: 8 sample steps plus 7 pulse-high steps, for 17 steps per frame.
  - Exactly 7 pulse highs per frame, each 1 step (6 us) wide.
  - Latch rises after POLL_STEPS idle steps.
  - Bit 0 is sampled 1 step after latch falls.
- valid is high exactly one inClock cycle per frame: the cycle after the final SHIFT_LO step.
- buttons holds its value between frames.
- latch and pulse are registered outputs, never high simultaneously, glitch-free.
- If stepClock stops, the FSM freezes in place with outputs held. There is no timeout.
- A stepClock edge coincident with reset==0: reset wins.

Test Plan:
- Reset: hold reset=0 for 5 cycles with stepClock=1 → all outputs 0. Release with stepClock still 1 → no step consumed; count stays 0 until the first real rising edge.
- Single frame, POLL_STEPS=4, stepClock toggling every 5 inClock cycles, pad model drives A and Start pressed (pattern 0,1,1,0,1,1,1,1 bit0 first) →
  - latch rises on the 4th step, stays high 2 steps;
  - 7 pulse highs;
  - buttons==8'h09 with one valid cycle, 17 steps after latch rise.
- All released (dataIn=1), then all pressed (dataIn=0) → buttons 8'h00 then 8'hFF across consecutive frames, one valid per frame. Frame period = POLL_STEPS+17 steps.
- Reset asserted during SHIFT_HI of bit 3, pad pattern differing from the prior frame →
  - latch, pulse, buttons go to 0 next cycle; no valid;
  - next full frame after release reports the correct byte.
- Stall stepClock mid-frame for 200 cycles → latch, pulse, state frozen. Frame completes correctly once toggling resumes.
- Glitch: dataIn pulses for 1 inClock cycle between steps → no effect on the sampled value if dataIn is stable ≥3 cycles before the sampling step.
